// File: rtl/alu_pipe.sv
// Pipelined signed ALU with a valid/ready handshake on both sides and optional saturation.
// The result is computed in one combinational step; stages 2..PIPE only delay it and freeze together on stall.
module alu_pipe #(
  parameter int WIDTH = 5,
  parameter int PIPE  = 2,
  parameter int SAT   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    alu_en,
  input  logic                    a_en,
  input  logic                    b_en,
  input  logic [2:0]              a_op,
  input  logic [1:0]              b_op,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH:0]   c,
  output logic                    err,
  output logic                    ovf
);
  localparam int W2 = WIDTH + 2;
  localparam logic signed [W2-1:0] MAXV = W2'((1 << (WIDTH-1)) - 1);
  localparam logic signed [W2-1:0] MINV = W2'(-(1 << (WIDTH-1)));

  function automatic logic signed [W2-1:0] sx(input logic [WIDTH-1:0] v);
    return {{2{v[WIDTH-1]}}, v};
  endfunction

  logic signed [W2-1:0]    ae, be, diff, r_d;
  logic signed [WIDTH:0]   c_d;
  logic                    err_d, ovf_d, stall;

  logic [PIPE:1]           vld_q;
  logic [PIPE:1][WIDTH:0]  c_q;
  logic [PIPE:1]           err_q, ovf_q;

  always_comb begin
    ae    = sx(a);
    be    = sx(b);
    diff  = ae - be;
    r_d   = '0;
    err_d = 1'b0;
    if (alu_en && a_en && !b_en) begin
      case (a_op)
        3'd0:    r_d = ae + be;
        3'd1:    r_d = diff;
        3'd2:    r_d = sx(a ^ b);
        3'd3:    r_d = sx(a & b);
        3'd4:    r_d = sx(a | b);
        3'd5:    r_d = sx(a ~^ b);
        3'd6:    r_d = (ae < be) ? ae : be;
        default: r_d = (ae > be) ? ae : be;
      endcase
    end else if (alu_en && b_en && !a_en) begin
      case (b_op)
        2'd0:    r_d = -ae;
        2'd1:    r_d = diff[W2-1] ? -diff : diff;
        2'd2:    r_d = ae + W2'(1);
        default: r_d = be - W2'(1);
      endcase
    end else if (alu_en) begin
      err_d = 1'b1;
    end
    // Bitwise/MIN/MAX always land in range, so a plain range test covers every op.
    ovf_d = (r_d > MAXV) || (r_d < MINV);
    c_d   = r_d[WIDTH:0];
    if (SAT != 0 && ovf_d) c_d = r_d[W2-1] ? MINV[WIDTH:0] : MAXV[WIDTH:0];
  end

  assign stall    = vld_q[PIPE] & ~out_ready;
  assign in_ready = ~stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      c_q   <= '0;
      err_q <= '0;
      ovf_q <= '0;
    end else if (!stall) begin
      vld_q[1] <= in_valid;
      c_q[1]   <= in_valid ? c_d : '0;
      err_q[1] <= in_valid & err_d;
      ovf_q[1] <= in_valid & ovf_d;
      for (int i = 2; i <= PIPE; i++) begin
        vld_q[i] <= vld_q[i-1];
        c_q[i]   <= c_q[i-1];
        err_q[i] <= err_q[i-1];
        ovf_q[i] <= ovf_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[PIPE];
  assign c         = c_q[PIPE];
  assign err       = err_q[PIPE];
  assign ovf       = ovf_q[PIPE];
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed vectors push expectations at accept, a monitor pops at each output handshake.
module tb_alu_pipe;
  localparam int WIDTH = 5;
  localparam int PIPE  = 2;
  localparam int SAT   = 0;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, alu_en, a_en, b_en, out_valid, out_ready, err, ovf;
  logic [2:0] a_op;
  logic [1:0] b_op;
  logic signed [WIDTH-1:0] a, b;
  logic signed [WIDTH:0]   c;

  int checks = 0;
  int errors = 0;

  typedef struct {int c; int err; int ovf;} exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(WIDTH), .PIPE(PIPE), .SAT(SAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_en(alu_en), .a_en(a_en), .b_en(b_en), .a_op(a_op), .b_op(b_op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .err(err), .ovf(ovf)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: inputs change on negedge, so by negedge+1 a pending output handshake is known.
  always @(negedge clk) begin
    exp_t e;
    int   cv;
    #1;
    if (!rst && out_valid && out_ready) begin
      cv = c;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output got c=%0d expected none", cv);
      end else begin
        e = q.pop_front();
        chk("c", cv, e.c);
        chk("err", int'(err), e.err);
        chk("ovf", int'(ovf), e.ovf);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input bit en, input bit ae, input bit be, input int aop, input int bop,
                       input int av, input int bv, input int ec0, input int ec1,
                       input int eerr, input int eovf);
    int n = 0;
    alu_en = en; a_en = ae; b_en = be;
    a_op = aop[2:0]; b_op = bop[1:0];
    a = av[WIDTH-1:0]; b = bv[WIDTH-1:0];
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) chk("in_ready_timeout", 0, 1);
    @(posedge clk);
    q.push_back('{(SAT != 0) ? ec1 : ec0, eerr, eovf});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 50) begin
      @(negedge clk); n++;
    end
    chk("drain_empty", q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_en = 1'b0; a_en = 1'b0; b_en = 1'b0; a_op = '0; b_op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_c", int'(c), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    rst = 1'b0;

    //     en ae be aop bop   a    b   c0   c1 err ovf
    issue(1, 1, 0, 0, 0,  15,  15,  30,  15, 0, 1); // ADD overflow
    issue(1, 1, 0, 1, 0, -16,  15, -31, -16, 0, 1); // SUB overflow
    issue(1, 0, 1, 0, 0, -16,   0,  16,  15, 0, 1); // NEG min
    issue(1, 1, 1, 0, 0,   4,   5,   0,   0, 1, 0); // illegal both set
    issue(0, 1, 0, 0, 0,   7,   7,   0,   0, 0, 0); // null transaction
    issue(1, 1, 0, 6, 0,  -3,   7,  -3,  -3, 0, 0); // MIN
    issue(1, 1, 0, 7, 0,  -3,   7,   7,   7, 0, 0); // MAX
    issue(1, 0, 1, 0, 1,  -3,   7,  10,  10, 0, 0); // ABSDIFF
    issue(1, 1, 0, 2, 0,   5,  -3,  -8,  -8, 0, 0); // XOR
    issue(1, 1, 0, 3, 0,   5,  -3,   5,   5, 0, 0); // AND
    issue(1, 1, 0, 4, 0,   5,  -3,  -3,  -3, 0, 0); // OR
    issue(1, 1, 0, 5, 0,   5,  -3,   7,   7, 0, 0); // XNOR
    issue(1, 0, 1, 0, 2,  15,   0,  16,  15, 0, 1); // INC overflow
    issue(1, 0, 1, 0, 3,   0, -16, -17, -16, 0, 1); // DEC overflow
    issue(1, 1, 0, 0, 0,  -4,   3,  -1,  -1, 0, 0); // ADD in range
    issue(1, 0, 1, 0, 1, -16,  15,  31,  15, 0, 1); // ABSDIFF extreme
    issue(1, 0, 0, 3, 2,   1,   1,   0,   0, 1, 0); // illegal none set
    issue(1, 1, 0, 1, 0,   3,   5,  -2,  -2, 0, 0); // SUB in range
    drain();

    // Back-pressure: stall 3 cycles from first out_valid while four ADDs stream in.
    fork
      begin
        issue(1, 1, 0, 0, 0, 1, 1, 2, 2, 0, 0);
        issue(1, 1, 0, 0, 0, 2, 2, 4, 4, 0, 0);
        issue(1, 1, 0, 0, 0, 3, 3, 6, 6, 0, 0);
        issue(1, 1, 0, 0, 0, 4, 4, 8, 8, 0, 0);
      end
      begin
        int n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 20);
        if (n >= 20) chk("bp_first_valid_timeout", 0, 1);
        out_ready = 1'b0;
        #1;
        chk("bp_in_ready", int'(in_ready), 0);
        chk("bp_c_hold", int'(c), 2);
        repeat (2) begin
          @(negedge clk); #1;
          chk("bp_c_hold", int'(c), 2);
          chk("bp_valid_hold", int'(out_valid), 1);
          chk("bp_in_ready", int'(in_ready), 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-stream: both in-flight results must vanish.
    issue(1, 1, 0, 0, 0, 6, 7, 13, 13, 0, 0);
    issue(1, 1, 0, 0, 0, 1, 2, 3, 3, 0, 0);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_c", int'(c), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    repeat (4) begin
      @(negedge clk); #1;
      chk("mid_rst_no_output", int'(out_valid), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
